// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter and its requester ports.
package arb_pkg;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned REQ_IDX_W = 2;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    // Narrow a port index parameter to the req/gnt index width.
    function automatic logic [REQ_IDX_W-1:0] req_idx(input int unsigned id);
        return REQ_IDX_W'(id);
    endfunction

endpackage : arb_pkg

// File: rtl/arb_req_fifo.sv
// Synchronous FIFO buffering producer words ahead of the arbiter grant.
module arb_req_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty flags and qualified push/pop; a full FIFO refuses a push even when popping.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : arb_req_fifo

// File: rtl/arb_req_port.sv
// Requester-side front end: buffers producer words, requests the arbiter,
// and pops one word onto an OR-combinable result bus per observed grant.
module arb_req_port
    import arb_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    input  logic [NUM_REQ-1:0]   gnt,
    output logic                 req,
    output logic                 bus_valid,
    output logic [DW-1:0]        bus_data,
    output logic [REQ_IDX_W-1:0] bus_id,
    output logic [7:0]           stale_cnt
);

    localparam int unsigned            CNT_W  = $clog2(DEPTH + 1);
    localparam logic [REQ_IDX_W-1:0]   ID_IDX = req_idx(ID);

    req_vec_t          gnt_vec;
    logic              my_gnt;
    logic              push;
    logic              pop;
    logic              stale;
    logic [DW-1:0]     head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    // Own grant bit only; other bits (even illegal multi-hot) are ignored.
    always_comb begin
        gnt_vec  = gnt;
        my_gnt   = gnt_vec[ID_IDX];
        in_ready = !full;
        push     = in_valid && in_ready;
        pop      = my_gnt && !empty;
        stale    = my_gnt && empty;
        // Look-ahead drops req while the last entry is being popped.
        req      = (count > CNT_W'(1)) || ((count == CNT_W'(1)) && !my_gnt);
    end

    arb_req_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Result bus register; zero when idle so ports can be OR-combined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_id    <= '0;
        end else if (pop) begin
            bus_valid <= 1'b1;
            bus_data  <= head;
            bus_id    <= ID_IDX;
        end else begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_id    <= '0;
        end
    end

    // Saturating count of grants that arrived with nothing to pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt <= 8'h00;
        end else if (stale && (stale_cnt != 8'hFF)) begin
            stale_cnt <= stale_cnt + 8'h01;
        end
    end

endmodule : arb_req_port

// File: tb/tb_arb_req_port.sv
// Self-checking bench for arb_req_port (ID=2, DEPTH=4) against a queue-based model.
module tb_arb_req_port;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID    = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [3:0]    gnt;
    logic          req;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic [1:0]    bus_id;
    logic [7:0]    stale_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] mq [$];
    int            m_stale;
    logic          m_bv;
    logic [DW-1:0] m_bd;
    logic [1:0]    m_bid;

    arb_req_port #(.DW(DW), .DEPTH(DEPTH), .ID(ID)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .gnt       (gnt),
        .req       (req),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_id    (bus_id),
        .stale_cnt (stale_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_stale = 0;
        m_bv    = 1'b0;
        m_bd    = '0;
        m_bid   = 2'd0;
    endtask

    function automatic logic exp_req();
        int n = mq.size();
        return (n > 1) || (n == 1 && !gnt[ID]);
    endfunction

    function automatic logic exp_ready();
        return mq.size() < DEPTH;
    endfunction

    // Set inputs (called just after a negedge) and let combinational outputs settle.
    task automatic set_in(input logic v, input logic [DW-1:0] d, input logic [3:0] g);
        in_valid = v;
        in_data  = d;
        gnt      = g;
        #1;
    endtask

    // Advance one clock: update the model from the rules at the edge, return at the next negedge.
    task automatic tick();
        logic p, u, st;
        int   n;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            n  = mq.size();
            p  = gnt[ID] && (n != 0);
            st = gnt[ID] && (n == 0);
            u  = in_valid && (n < DEPTH);
            m_bv  = p;
            m_bd  = p ? mq[0] : '0;
            m_bid = p ? 2'(ID) : 2'd0;
            if (p) void'(mq.pop_front());
            if (u) mq.push_back(in_data);
            if (st && m_stale < 255) m_stale++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        set_in(1'b1, 32'hDEAD_BEEF, 4'b0000);
        repeat (3) tick();
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL reset_bus_valid: got %b want 0", bus_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({bus_data, bus_id, stale_cnt} !== 42'd0) begin n_err++;
            $display("FAIL reset_bus_zero: data %h id %0d stale %0d want all 0", bus_data, bus_id, stale_cnt); end
        rst_n = 1'b1;
        set_in(1'b0, '0, 4'b0000);
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_release_req: got %b want 0", req); end
    endtask

    task automatic test_basic_id2();
        set_in(1'b1, 32'hA1, 4'b0000); tick();
        set_in(1'b1, 32'hA2, 4'b0000); tick();
        set_in(1'b0, '0, 4'b0100);
        n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL basic_req_g1: got %b want 1", req); end
        tick();
        n_cmp++; if ({bus_valid, bus_data, bus_id} !== {1'b1, 32'hA1, 2'd2}) begin n_err++;
            $display("FAIL basic_pop1: got v%b %h id%0d want v1 a1 id2", bus_valid, bus_data, bus_id); end
        set_in(1'b0, '0, 4'b0100);
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL basic_req_fall: got %b want 0", req); end
        tick();
        n_cmp++; if ({bus_valid, bus_data, bus_id} !== {1'b1, 32'hA2, 2'd2}) begin n_err++;
            $display("FAIL basic_pop2: got v%b %h id%0d want v1 a2 id2", bus_valid, bus_data, bus_id); end
        set_in(1'b0, '0, 4'b0000); tick();
        n_cmp++; if ({bus_valid, bus_data, bus_id} !== 35'd0) begin n_err++;
            $display("FAIL basic_idle: got v%b %h id%0d want all 0", bus_valid, bus_data, bus_id); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'hF0 + 32'(i), 4'b0000);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); end
            tick();
        end
        set_in(1'b1, 32'h55, 4'b0000);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b want 0", in_ready); end
        tick();
        // Full with a grant: pop happens but the offered word is still refused.
        set_in(1'b1, 32'h66, 4'b0100);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_pop: got %b want 0", in_ready); end
        tick();
        n_cmp++; if ({bus_valid, bus_data} !== {1'b1, 32'hF0}) begin n_err++;
            $display("FAIL fill_pop_head: got v%b %h want v1 f0", bus_valid, bus_data); end
        set_in(1'b0, '0, 4'b0000);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_after: got %b want 1", in_ready); end
        for (int i = 1; i < 4; i++) begin
            set_in(1'b0, '0, 4'b0100); tick();
            n_cmp++; if ({bus_valid, bus_data} !== {1'b1, 32'hF0 + 32'(i)}) begin n_err++;
                $display("FAIL fill_drain_%0d: got v%b %h want v1 %h", i, bus_valid, bus_data, 32'hF0 + 32'(i)); end
        end
        set_in(1'b0, '0, 4'b0000); tick();
    endtask

    task automatic test_foreign_gnt();
        int s0;
        set_in(1'b1, 32'hB1, 4'b0000); tick();
        s0 = m_stale;
        set_in(1'b0, '0, 4'b1011);
        n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL foreign_req: got %b want 1", req); end
        tick();
        n_cmp++; if ({bus_valid, stale_cnt} !== {1'b0, 8'(s0)}) begin n_err++;
            $display("FAIL foreign_nopop: got v%b stale %0d want v0 stale %0d", bus_valid, stale_cnt, s0); end
        set_in(1'b0, '0, 4'b0111);
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL multihot_req: got %b want 0", req); end
        tick();
        n_cmp++; if ({bus_valid, bus_data, bus_id} !== {1'b1, 32'hB1, 2'd2}) begin n_err++;
            $display("FAIL multihot_pop: got v%b %h id%0d want v1 b1 id2", bus_valid, bus_data, bus_id); end
        set_in(1'b0, '0, 4'b0000); tick();
    endtask

    task automatic test_stale();
        set_in(1'b0, '0, 4'b0100); tick();
        n_cmp++; if ({bus_valid, stale_cnt} !== {1'b0, 8'd1}) begin n_err++;
            $display("FAIL stale_first: got v%b stale %0d want v0 stale 1", bus_valid, stale_cnt); end
        for (int i = 0; i < 299; i++) tick();
        n_cmp++; if (stale_cnt !== 8'hFF || m_stale != 255) begin n_err++;
            $display("FAIL stale_sat: got %h want ff (model %0d)", stale_cnt, m_stale); end
        set_in(1'b0, '0, 4'b0000); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 99) < 60), $urandom, 4'($urandom));
            n_cmp++; if ({in_ready, req} !== {exp_ready(), exp_req()}) begin n_err++;
                $display("FAIL rand_comb_%0d: got rdy%b req%b want rdy%b req%b", i, in_ready, req, exp_ready(), exp_req()); end
            tick();
            n_cmp++; if ({bus_valid, bus_data, bus_id, stale_cnt} !== {m_bv, m_bd, m_bid, 8'(m_stale)}) begin n_err++;
                $display("FAIL rand_bus_%0d: got v%b %h id%0d st%0d want v%b %h id%0d st%0d",
                         i, bus_valid, bus_data, bus_id, stale_cnt, m_bv, m_bd, m_bid, m_stale); end
        end
        set_in(1'b0, '0, 4'b0000); tick();
    endtask

    task automatic test_reset_mid_drain();
        // Empty the FIFO, load four words, pop one so three remain.
        for (int i = 0; i < 8 && mq.size() != 0; i++) begin set_in(1'b0, '0, 4'b0100); tick(); end
        for (int i = 0; i < 4; i++) begin set_in(1'b1, 32'hC0 + 32'(i), 4'b0000); tick(); end
        set_in(1'b0, '0, 4'b0100); tick();
        n_cmp++; if ({bus_valid, req} !== 2'b11 || mq.size() != 3) begin n_err++;
            $display("FAIL middrain_pre: got v%b req%b want v1 req1 (model depth %0d)", bus_valid, req, mq.size()); end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({req, in_ready, bus_valid} !== 3'b010) begin n_err++;
            $display("FAIL middrain_async: got req%b rdy%b v%b want req0 rdy1 v0", req, in_ready, bus_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, '0, 4'b0100); tick();
        n_cmp++; if ({bus_valid, stale_cnt} !== {1'b0, 8'd1}) begin n_err++;
            $display("FAIL middrain_after: got v%b stale %0d want v0 stale 1", bus_valid, stale_cnt); end
        set_in(1'b0, '0, 4'b0000); tick();
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = 4'b0000;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_id2();
        test_fill();
        test_foreign_gnt();
        test_stale();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_arb_req_port
